// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the Cortex-M0 multi-cycle shift sequencer:
//   - shift-type encodings (matching the decode stage's 2-bit stype field)
//   - sequencer FSM states
//   - iteration cap that makes LSL/LSR/ASR by >= 32 come out architecturally
// -----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } stype_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // 33 single-bit steps: the 32nd shifts out the last data bit into C,
    // the 33rd shifts a zero (or the sign for ASR) into C.
    localparam int SH_MAX_ITER = 33;

    // ROR by a non-zero multiple of 32 does no stepping but still reports
    // C = Rm[31].
    function automatic logic ror_wraps(input logic [7:0] amt);
        return (amt != 8'd0) && (amt[4:0] == 5'd0);
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational one-position shift of the working register.
//
// Ports:
//   i_stype  shift type (LSL/LSR/ASR/ROR)
//   i_reg    current working register
//   o_reg    working register after one position
//   o_carry  bit shifted out by this position
// -----------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  stype_e              i_stype,
    input  logic [DATA_W-1:0]   i_reg,
    output logic [DATA_W-1:0]   o_reg,
    output logic                o_carry
);

    always_comb begin
        o_reg   = i_reg;
        o_carry = i_reg[0];
        case (i_stype)
            SH_LSL: begin
                o_carry = i_reg[DATA_W-1];
                o_reg   = {i_reg[DATA_W-2:0], 1'b0};
            end
            SH_LSR: begin
                o_reg   = {1'b0, i_reg[DATA_W-1:1]};
            end
            SH_ASR: begin
                o_reg   = {i_reg[DATA_W-1], i_reg[DATA_W-1:1]};
            end
            SH_ROR: begin
                o_reg   = {i_reg[0], i_reg[DATA_W-1:1]};
            end
            default: begin
                o_reg   = i_reg;
                o_carry = i_reg[0];
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle controller for the Cortex-M0 shifter (LSL, LSR, ASR, ROR).
// Shifts one position per clock (two with SHIFT_DUAL_STEP_EN defined) and
// produces the ARMv6-M result plus C/Z/N flags behind a start/busy/done
// handshake.
//
// Build option:
//   SHIFT_DUAL_STEP_EN  two positions per SHIFT cycle (last step single when
//                       an odd count remains); results identical.
//
// Ports:
//   clk                           rising-edge clock
//   rst                           synchronous active-high reset
//   start                         request, sampled only in IDLE
//   S                             update flags when 1, else pass through
//   stype                         00 LSL, 01 LSR, 10 ASR, 11 ROR
//   Rm                            operand
//   amount                        shift amount 0..255 (Rs[7:0])
//   carry_in, zero_in, neg_in     current APSR C/Z/N
//   busy                          high while shifting
//   done                          one-cycle pulse, results valid
//   Rd                            result, held until next accepted start
//   carry_out, zero_out, neg_out  resulting flags, held likewise
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              S,
    input  logic [1:0]        stype,
    input  logic [DATA_W-1:0] Rm,
    input  logic [CNT_W-1:0]  amount,
    input  logic              carry_in,
    input  logic              zero_in,
    input  logic              neg_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Rd,
    output logic              carry_out,
    output logic              zero_out,
    output logic              neg_out
);

    state_e              r_state;
    state_e              w_state_nxt;

    logic [DATA_W-1:0]   r_work;
    logic                r_carry;
    logic [CNT_W-1:0]    r_cnt;
    stype_e              r_stype;
    logic                r_s;
    logic                r_cin;
    logic                r_zin;
    logic                r_nin;

    logic [DATA_W-1:0]   r_rd;
    logic                r_cout;
    logic                r_zout;
    logic                r_nout;

    logic [CNT_W-1:0]    w_n;
    logic                w_c_init;
    logic [DATA_W-1:0]   w_reg1;
    logic                w_c1;
    logic [DATA_W-1:0]   w_step_reg;
    logic                w_step_c;
    logic                w_last;
    logic [CNT_W-1:0]    w_cnt_dec;

    logic [DATA_W-1:0]   w_fin_reg;
    logic                w_fin_c;
    logic                w_fin_s;
    logic [2:0]          w_fin_fl;
    logic                w_load_out;

    // Iteration count: ROR only needs amount mod 32; the others saturate at
    // 33 so the final C is the architectural one for any amount >= 32.
    always_comb begin
        if (stype_e'(stype) == SH_ROR)
            w_n = CNT_W'(amount[4:0]);
        else if (amount > CNT_W'(SH_MAX_ITER))
            w_n = CNT_W'(SH_MAX_ITER);
        else
            w_n = amount;
    end

    assign w_c_init = ((stype_e'(stype) == SH_ROR) && ror_wraps(8'(amount)))
                      ? Rm[DATA_W-1] : carry_in;

    shift_step #(.DATA_W(DATA_W)) u_step0 (
        .i_stype (r_stype),
        .i_reg   (r_work),
        .o_reg   (w_reg1),
        .o_carry (w_c1)
    );

`ifdef SHIFT_DUAL_STEP_EN
    logic [DATA_W-1:0]   w_reg2;
    logic                w_c2;
    logic                w_two;

    shift_step #(.DATA_W(DATA_W)) u_step1 (
        .i_stype (r_stype),
        .i_reg   (w_reg1),
        .o_reg   (w_reg2),
        .o_carry (w_c2)
    );

    // Take two positions unless only one remains.
    assign w_two      = (r_cnt >= CNT_W'(2));
    assign w_step_reg = w_two ? w_reg2 : w_reg1;
    assign w_step_c   = w_two ? w_c2   : w_c1;
    assign w_cnt_dec  = w_two ? (r_cnt - CNT_W'(2)) : (r_cnt - CNT_W'(1));
    assign w_last     = (r_cnt <= CNT_W'(2));
`else
    assign w_step_reg = w_reg1;
    assign w_step_c   = w_c1;
    assign w_cnt_dec  = r_cnt - CNT_W'(1);
    assign w_last     = (r_cnt == CNT_W'(1));
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = (w_n == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Final values are taken either straight from the request (zero
    // iterations) or from the last shift step, so the output registers are
    // loaded on the edge that enters DONE and are valid during it.
    always_comb begin
        w_fin_reg = w_step_reg;
        w_fin_c   = w_step_c;
        w_fin_s   = r_s;
        w_fin_fl  = {r_cin, r_zin, r_nin};
        if (r_state == ST_IDLE) begin
            w_fin_reg = Rm;
            w_fin_c   = w_c_init;
            w_fin_s   = S;
            w_fin_fl  = {carry_in, zero_in, neg_in};
        end
    end

    assign w_load_out = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_stype <= SH_LSL;
            r_s     <= 1'b0;
            r_cin   <= 1'b0;
            r_zin   <= 1'b0;
            r_nin   <= 1'b0;
            r_rd    <= '0;
            r_cout  <= 1'b0;
            r_zout  <= 1'b0;
            r_nout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work  <= Rm;
                        r_carry <= w_c_init;
                        r_cnt   <= w_n;
                        r_stype <= stype_e'(stype);
                        r_s     <= S;
                        r_cin   <= carry_in;
                        r_zin   <= zero_in;
                        r_nin   <= neg_in;
                    end
                end
                ST_SHIFT: begin
                    r_work  <= w_step_reg;
                    r_carry <= w_step_c;
                    r_cnt   <= w_cnt_dec;
                end
                default: ;
            endcase

            if (w_load_out) begin
                r_rd <= w_fin_reg;
                if (w_fin_s) begin
                    r_cout <= w_fin_c;
                    r_zout <= (w_fin_reg == '0);
                    r_nout <= w_fin_reg[DATA_W-1];
                end else begin
                    {r_cout, r_zout, r_nout} <= w_fin_fl;
                end
            end
        end
    end

    assign Rd        = r_rd;
    assign carry_out = r_cout;
    assign zero_out  = r_zout;
    assign neg_out   = r_nout;

endmodule
